// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types and constants for the VPU writeback path.
// Provides the lane data width, the packed Unified Buffer word and the writeback FSM states.
package tpu_pkg;
   localparam int DATA_W = 16;
   typedef logic [2*DATA_W-1:0] ub_word_t;
   typedef enum logic [1:0] {IDLE, RUN, DONE} wb_state_t;
endpackage

// File: rtl/wb_skew_fifo.sv
// wb_skew_fifo: lane-1 deskew FIFO with same-cycle bypass when empty.
// Ports: clk, rst (async active-low), i_flush (sync clear), i_push/i_data (write),
//        i_pop (read head), o_data (head, or i_data when empty), o_full, o_empty, o_count.
module wb_skew_fifo
   import tpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [DATA_W-1:0]        i_data,
   output logic [DATA_W-1:0]        o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [AW-1:0]     r_wp, r_rp;
   logic [CW-1:0]     r_cnt;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              w_wr, w_rd;
   assign o_empty = r_cnt == '0;
   assign o_full  = r_cnt == CW'(DEPTH);
   assign o_count = r_cnt;
   assign o_data  = o_empty ? i_data : r_mem[r_rp];
   // push+pop on empty passes straight through and leaves storage untouched
   assign w_rd = i_pop && !o_empty;
   assign w_wr = i_push && (!o_full || i_pop) && !(o_empty && i_pop);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_wr) r_wp <= r_wp + AW'(1);
         if (w_rd) r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
      end
   end
   always_ff @(posedge clk) begin
      if (w_wr && !i_flush) r_mem[r_wp] <= i_data;
   end
endmodule

// File: rtl/vpu_writeback.sv
// vpu_writeback: pairs skewed VPU lane outputs and writes them as 32-bit words to the Unified Buffer.
// Ports: clk, rst (async active-low); job control wb_start/wb_abort/wb_base_addr/wb_row_count;
//        VPU lanes vpu_data_out_1/2 + vpu_valid_out_1/2; UB write ub_wr_en/ub_wr_addr/ub_wr_data;
//        status wb_busy, wb_done, err_overflow, err_underflow (all outputs registered).
module vpu_writeback
   import tpu_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int SKEW_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_start,
   input  logic                     wb_abort,
   input  logic [ADDR_W-1:0]        wb_base_addr,
   input  logic [ADDR_W-1:0]        wb_row_count,
   input  logic signed [DATA_W-1:0] vpu_data_out_1,
   input  logic signed [DATA_W-1:0] vpu_data_out_2,
   input  logic                     vpu_valid_out_1,
   input  logic                     vpu_valid_out_2,
   output logic                     ub_wr_en,
   output logic [ADDR_W-1:0]        ub_wr_addr,
   output ub_word_t                 ub_wr_data,
   output logic                     wb_busy,
   output logic                     wb_done,
   output logic                     err_overflow,
   output logic                     err_underflow
);
   wb_state_t                   r_state, w_state_nx;
   logic [ADDR_W-1:0]           r_base, r_count, r_k;
   logic                        w_start, w_run, w_push, w_pop, w_pair, w_flush, w_full, w_empty;
   logic [DATA_W-1:0]           w_head;
   logic [$clog2(SKEW_DEPTH):0] w_occ;
   assign w_start = r_state == IDLE && wb_start;
   // once all pairs are accepted (r_k == r_count) lanes are ignored while the last write drains
   assign w_run   = r_state == RUN && !wb_abort && r_k != r_count;
   assign w_push  = w_run && vpu_valid_out_1;
   assign w_pop   = w_run && vpu_valid_out_2;
   assign w_pair  = w_pop && (!w_empty || w_push);
   assign w_flush = w_start || r_state == DONE || (r_state == RUN && wb_abort);
   wb_skew_fifo #(.DEPTH(SKEW_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_flush),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (vpu_data_out_1),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_occ)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nx;
   end
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE:    w_state_nx = wb_start ? (wb_row_count == '0 ? DONE : RUN) : IDLE;
         RUN:     w_state_nx = wb_abort ? IDLE : (r_k == r_count ? DONE : RUN);
         default: w_state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_base        <= '0;
         r_count       <= '0;
         r_k           <= '0;
         ub_wr_en      <= 1'b0;
         ub_wr_addr    <= '0;
         ub_wr_data    <= '0;
         wb_busy       <= 1'b0;
         wb_done       <= 1'b0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         ub_wr_en <= w_pair;
         wb_busy  <= w_state_nx == RUN;
         wb_done  <= w_state_nx == DONE;
         if (w_pair) begin
            ub_wr_addr <= r_base + r_k;
            ub_wr_data <= {vpu_data_out_2, w_head};
            r_k        <= r_k + ADDR_W'(1);
         end
         if (w_start) begin
            r_base        <= wb_base_addr;
            r_count       <= wb_row_count;
            r_k           <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
         end else begin
            // leftover lane-1 data at job end counts as overflow
            if ((w_push && w_full && !w_pop) ||
                (r_state == RUN && w_state_nx == DONE && w_occ != '0)) err_overflow <= 1'b1;
            if (w_pop && w_empty && !w_push) err_underflow <= 1'b1;
         end
      end
   end
endmodule

// File: doc/vpu_writeback.md
VPU_WRITEBACK -- requirements
Module: vpu_writeback

Interface
REQ-001 Parameter: ADDR_W, default 8, Unified Buffer (UB) word address width.
REQ-002 Parameter: SKEW_DEPTH, default 4, lane-1 deskew FIFO depth, a power of two of at least 2.
REQ-003 Port: clk  in  1  the single clock; all logic is rising-edge.
REQ-004 Port: rst  in  1  reset, asynchronous and active-low.
REQ-005 Port: wb_start  in  1  one-cycle job start pulse.
REQ-006 Port: wb_abort  in  1  synchronous job cancel.
REQ-007 Port: wb_base_addr  in  ADDR_W  first UB write address.
REQ-008 Port: wb_row_count  in  ADDR_W  number of row pairs to write.
REQ-009 Port: vpu_data_out_1 / vpu_data_out_2  in  16 signed each  VPU lane data.
REQ-010 Port: vpu_valid_out_1 / vpu_valid_out_2  in  1 each  VPU lane valids; lane 2 lags lane 1 by the systolic skew.
REQ-011 Port: ub_wr_en  out  1  UB write strobe.
REQ-012 Port: ub_wr_addr  out  ADDR_W  UB write address.
REQ-013 Port: ub_wr_data  out  32  packed row pair: [15:0] lane 1, [31:16] lane 2.
REQ-014 Port: wb_busy  out  1  high while a job is active.
REQ-015 Port: wb_done  out  1  one-cycle job-complete pulse.
REQ-016 Port: err_overflow / err_underflow  out  1 each  sticky error flags.

Function
REQ-017 State machine: IDLE, RUN, DONE; wb_busy=1 in RUN only.
REQ-018 IDLE with wb_start=1: latch base and count, clear the write counter k, both error flags and the FIFO, then go to RUN.
REQ-019 wb_start with wb_row_count=0: go to DONE directly, with no writes.
REQ-020 wb_start while in RUN or DONE is ignored.
REQ-021 Lane valids outside RUN are ignored: no push, no pop, no error.
REQ-022 RUN, vpu_valid_out_1=1: push vpu_data_out_1 into the deskew FIFO.
REQ-023 RUN, vpu_valid_out_2=1: pop the FIFO head and pair it with vpu_data_out_2.
REQ-024 A pair accepted in cycle t appears on ub_wr_en/ub_wr_addr/ub_wr_data in cycle t+1, registered.
REQ-025 Write address is (base + k) mod 2^ADDR_W; k increments per write, and address wrap is silent.
REQ-026 Simultaneous push and pop is legal at any occupancy, including full and empty, with a same-cycle bypass when empty.
REQ-027 Push when full without a simultaneous pop: drop the data and set err_overflow.
REQ-028 Pop when empty without a simultaneous push: no write, and set err_underflow.
REQ-029 When the write for k = count-1 issues: RUN goes to DONE, and further lane valids in that cycle are ignored.
REQ-030 DONE lasts exactly one cycle: wb_done=1, the FIFO is flushed, and the next state is IDLE.
REQ-031 FIFO occupancy other than 0 on entry to DONE sets err_overflow.
REQ-032 wb_abort=1 in RUN: go to IDLE next cycle, flush the FIFO, no wb_done, and drop any in-flight write; wb_abort has priority over the lane valids.
REQ-033 Error flags hold until the next accepted wb_start or reset.

Reset
REQ-034 Asserting rst (low) immediately forces: state IDLE, FIFO empty, k=0, and all outputs 0 (ub_wr_en, ub_wr_addr, ub_wr_data, wb_busy, wb_done, err_overflow, err_underflow).
REQ-035 Reset mid-job discards the job with no wb_done; release is synchronous to clk.

Structure
REQ-036 Shared package tpu_pkg holds: DATA_W=16, the 32-bit ub_word_t type, and the wb_state_t enum.
REQ-037 The deskew FIFO is the sub-module wb_skew_fifo, with push/pop/full/empty/count and synchronous flush.
REQ-038 All outputs are registered; there is no combinational path from inputs to ub_* outputs.

Verification
REQ-039 Basic pairing: base=0x10, count=3; lane 1 = 1,2,3 on cycles 0-2; lane 2 = 4,5,6 on cycles 1-3.
  Required: writes 0x10=0x00040001, 0x11=0x00050002, 0x12=0x00060003; wb_done one cycle after the last write.
REQ-040 Wrap: base=0xFE, count=3, ADDR_W=8.
  Required: write addresses 0xFE, 0xFF, 0x00.
REQ-041 Overflow: five lane-1 valids with no lane-2 valids, depth 4.
  Required: err_overflow=1 and four entries kept; an extra lane-2 valid with the FIFO empty sets err_underflow.
REQ-042 count=0 start.
  Required: wb_done the next cycle, ub_wr_en never asserted.
REQ-043 Abort: wb_abort after 1 of 3 writes.
  Required: IDLE, no wb_done, no further writes; a new start then runs cleanly.
REQ-044 Reset mid-RUN with 2 FIFO entries.
  Required: all outputs 0 immediately; after release, a full job writes correct data.
